// File: rtl/if_stage_if.sv
// Bundle of fetch-stage control, redirect, memory and debug-counter signals
// shared between the instruction-fetch stage and its surrounding pipeline.
interface if_stage_if #(
    parameter int CNT_W = 32
);
    logic             PC_Keep;
    logic             IF_ID_Hold;
    logic             IF_ID_Flush;
    logic             Jump;
    logic [31:0]      jump_target;
    logic             if_branch;
    logic [31:0]      branch_target;
    logic [31:0]      imem_rdata;
    logic             cnt_clr;
    logic [31:0]      imem_addr;
    logic [31:0]      IF_ID_Instruction;
    logic [31:0]      IF_ID_PC4;
    logic             IF_ID_Valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output PC_Keep, IF_ID_Hold, IF_ID_Flush, Jump, jump_target,
               if_branch, branch_target, imem_rdata, cnt_clr,
        input  imem_addr, IF_ID_Instruction, IF_ID_PC4, IF_ID_Valid,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  PC_Keep, IF_ID_Hold, IF_ID_Flush, Jump, jump_target,
               if_branch, branch_target, imem_rdata, cnt_clr,
        output imem_addr, IF_ID_Instruction, IF_ID_PC4, IF_ID_Valid,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register with redirect/stall selection, IF/ID
// pipeline register, and saturating stall/flush event counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          CNT_W    = 32
) (
    input  logic      clk,
    input  logic      reset,
    if_stage_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    logic [31:0]      pc_q,       pc_d;
    logic [31:0]      instr_q,    instr_d;
    logic [31:0]      pc4_q,      pc4_d;
    logic             valid_q,    valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [31:0]      pc_plus4_s;
    logic             stall_evt_s;

    assign pc_plus4_s  = pc_q + 32'd4;
    // A redirect from an older instruction cancels the stall, so it is not counted.
    assign stall_evt_s = bus.PC_Keep & ~bus.if_branch & ~bus.Jump;

    // Next-PC selection: branch, then jump, then hold, then sequential.
    always_comb begin
        pc_d = pc_plus4_s;
        if (bus.if_branch) begin
            pc_d = align_word(bus.branch_target);
        end else if (bus.Jump) begin
            pc_d = align_word(bus.jump_target);
        end else if (bus.PC_Keep) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_plus4_s;
        end
    end

    // IF/ID next value: flush wins over hold.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (bus.IF_ID_Flush) begin
            instr_d = 32'h0000_0000;
            pc4_d   = 32'h0000_0000;
            valid_d = 1'b0;
        end else if (bus.IF_ID_Hold) begin
            instr_d = instr_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
        end else begin
            instr_d = bus.imem_rdata;
            pc4_d   = pc_plus4_s;
            valid_d = 1'b1;
        end
    end

    // Saturating event counters with synchronous clear.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_evt_s && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (bus.IF_ID_Flush && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0000_0000;
            pc4_q       <= 32'h0000_0000;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.imem_addr         = pc_q;
    assign bus.IF_ID_Instruction = instr_q;
    assign bus.IF_ID_PC4         = pc4_q;
    assign bus.IF_ID_Valid       = valid_q;
    assign bus.stall_cnt         = stall_cnt_q;
    assign bus.flush_cnt         = flush_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with 4-bit counters so that
// saturation is reachable in a short run.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    if_stage_if #(.CNT_W(4)) bus ();

    if_stage #(.RESET_PC(RST_PC), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], ~addr[31:16]};
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        bus.PC_Keep       = 1'b0;
        bus.IF_ID_Hold    = 1'b0;
        bus.IF_ID_Flush   = 1'b0;
        bus.Jump          = 1'b0;
        bus.jump_target   = 32'h0000_0000;
        bus.if_branch     = 1'b0;
        bus.branch_target = 32'h0000_0000;
        bus.cnt_clr       = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},    bus.imem_addr,                 RST_PC);
        check({tag, "_instr"}, bus.IF_ID_Instruction,         32'h0000_0000);
        check({tag, "_pc4"},   bus.IF_ID_PC4,                 32'h0000_0000);
        check({tag, "_valid"}, {31'd0, bus.IF_ID_Valid},      32'd0);
        check({tag, "_scnt"},  {28'd0, bus.stall_cnt},        32'd0);
        check({tag, "_fcnt"},  {28'd0, bus.flush_cnt},        32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        clear_ctl();
        #12;
        check_reset_state("rst");
        rst_n = 1'b1;
        check("boot_pc0", bus.imem_addr, 32'h0040_0000);

        tick();
        check("boot_pc1",    bus.imem_addr,              32'h0040_0004);
        check("boot_pc4_1",  bus.IF_ID_PC4,              32'h0040_0004);
        check("boot_valid",  {31'd0, bus.IF_ID_Valid},   32'd1);
        check("boot_instr1", bus.IF_ID_Instruction,      mem_word(32'h0040_0000));
        tick();
        check("boot_pc2",    bus.imem_addr,              32'h0040_0008);
        check("boot_pc4_2",  bus.IF_ID_PC4,              32'h0040_0008);
        check("boot_instr2", bus.IF_ID_Instruction,      mem_word(32'h0040_0004));

        // load-use stall for one cycle
        bus.PC_Keep    = 1'b1;
        bus.IF_ID_Hold = 1'b1;
        tick();
        check("stall_pc",    bus.imem_addr,              32'h0040_0008);
        check("stall_pc4",   bus.IF_ID_PC4,              32'h0040_0008);
        check("stall_instr", bus.IF_ID_Instruction,      mem_word(32'h0040_0004));
        check("stall_cnt",   {28'd0, bus.stall_cnt},     32'd1);
        clear_ctl();
        tick();
        check("resume_pc",    bus.imem_addr,             32'h0040_000C);
        check("resume_instr", bus.IF_ID_Instruction,     mem_word(32'h0040_0008));

        // jump with flush
        bus.Jump        = 1'b1;
        bus.jump_target = 32'h0040_0100;
        bus.IF_ID_Flush = 1'b1;
        tick();
        check("jump_pc",    bus.imem_addr,               32'h0040_0100);
        check("jump_valid", {31'd0, bus.IF_ID_Valid},    32'd0);
        check("jump_instr", bus.IF_ID_Instruction,       32'h0000_0000);
        check("jump_pc4",   bus.IF_ID_PC4,               32'h0000_0000);
        check("jump_fcnt",  {28'd0, bus.flush_cnt},      32'd1);
        clear_ctl();
        tick();
        check("postjump_pc",    bus.imem_addr,           32'h0040_0104);
        check("postjump_valid", {31'd0, bus.IF_ID_Valid}, 32'd1);
        check("postjump_instr", bus.IF_ID_Instruction,   mem_word(32'h0040_0100));

        // everything asserted at once: branch wins, flush beats hold
        bus.if_branch     = 1'b1;
        bus.branch_target = 32'h0040_0200;
        bus.Jump          = 1'b1;
        bus.jump_target   = 32'h0040_0300;
        bus.PC_Keep       = 1'b1;
        bus.IF_ID_Hold    = 1'b1;
        bus.IF_ID_Flush   = 1'b1;
        tick();
        check("all_pc",    bus.imem_addr,                32'h0040_0200);
        check("all_valid", {31'd0, bus.IF_ID_Valid},     32'd0);
        check("all_instr", bus.IF_ID_Instruction,        32'h0000_0000);
        check("all_scnt",  {28'd0, bus.stall_cnt},       32'd1);
        check("all_fcnt",  {28'd0, bus.flush_cnt},       32'd2);
        clear_ctl();

        // misaligned branch target and PC wrap
        bus.if_branch     = 1'b1;
        bus.branch_target = 32'hFFFF_FFFE;
        tick();
        check("align_pc",  bus.imem_addr,                32'hFFFF_FFFC);
        check("align_pc4", bus.IF_ID_PC4,                32'h0040_0204);
        clear_ctl();
        tick();
        check("wrap_pc",    bus.imem_addr,               32'h0000_0000);
        check("wrap_pc4",   bus.IF_ID_PC4,               32'h0000_0000);
        check("wrap_instr", bus.IF_ID_Instruction,       mem_word(32'hFFFF_FFFC));

        // jump overriding PC_Keep is not a stall
        bus.Jump        = 1'b1;
        bus.jump_target = 32'h0040_0013;
        bus.PC_Keep     = 1'b1;
        tick();
        check("jk_pc",   bus.imem_addr,                  32'h0040_0010);
        check("jk_scnt", {28'd0, bus.stall_cnt},         32'd1);
        clear_ctl();

        // counter saturation
        bus.PC_Keep = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("sat_scnt", {28'd0, bus.stall_cnt},        32'd15);
        check("sat_pc",   bus.imem_addr,                 32'h0040_0010);

        bus.cnt_clr = 1'b1;
        tick();
        check("clr_scnt", {28'd0, bus.stall_cnt},        32'd0);
        check("clr_fcnt", {28'd0, bus.flush_cnt},        32'd0);
        bus.cnt_clr = 1'b0;
        tick();
        check("reinc_scnt", {28'd0, bus.stall_cnt},      32'd1);

        // asynchronous reset mid-stall, observed before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        clear_ctl();
        tick();
        check("midrst_hold_pc", bus.imem_addr,           RST_PC);
        rst_n = 1'b1;
        tick();
        check("restart_pc",  bus.imem_addr,              32'h0040_0004);
        check("restart_pc4", bus.IF_ID_PC4,              32'h0040_0004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined CPU: PC register, next-PC selection, and the IF/ID pipeline register.
- Consumes the stall/flush controls from the hazard unit (PC_Keep, IF_ID_Hold, IF_ID_Flush) and the redirect requests from ID (jump) and EX (branch).
- Drives the instruction-memory address and presents the fetched instruction, PC+4 and a valid bit to the decode stage.
- Also keeps saturating stall/flush event counters for performance debug.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- CNT_W, 32, width of stall and flush counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- PC_Keep  in  1  hold the PC (load-use stall).
- IF_ID_Hold  in  1  hold the IF/ID register.
- IF_ID_Flush  in  1  squash the IF/ID register.
- Jump  in  1  jump redirect from ID.
- jump_target  in  32  jump destination.
- if_branch  in  1  taken-branch redirect from EX.
- branch_target  in  32  branch destination.
- imem_rdata  in  32  instruction read combinationally at imem_addr.
- cnt_clr  in  1  synchronous clear of both counters.
- imem_addr  out  32  current PC (equals the PC register).
- IF_ID_Instruction  out  32  registered instruction.
- IF_ID_PC4  out  32  registered PC+4 of that instruction.
- IF_ID_Valid  out  1  registered instruction is real (0 = bubble).
- stall_cnt  out  CNT_W  cycles in which the PC was actually held.
- flush_cnt  out  CNT_W  cycles in which IF/ID was flushed.

Behaviour:
- Reset (asynchronous, active-low), taking effect immediately:
  - PC = RESET_PC.
  - IF_ID_Instruction = 0, IF_ID_PC4 = 0, IF_ID_Valid = 0.
  - stall_cnt = 0, flush_cnt = 0.
- Reset asserted mid-operation discards all in-flight state.
- Fetch restarts at RESET_PC on the first rising edge after reset deasserts.
- imem_addr is the PC register directly; there is no combinational path from the inputs.
- Next-PC priority, highest first:
  - if_branch -> branch_target.
  - Jump -> jump_target.
  - PC_Keep -> PC unchanged.
  - Otherwise PC+4.
- A redirect overrides PC_Keep because the older instruction wins.
- Target bits [1:0] are forced to 0 when loaded.
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- IF/ID update priority, highest first:
  - IF_ID_Flush -> instruction = 32'h0 (nop), PC4 = 0, valid = 0.
  - IF_ID_Hold -> all three fields unchanged.
  - Otherwise load imem_rdata, PC+4 and valid = 1.
- Flush beats hold when both are asserted in the same cycle.
- IF/ID latency: the instruction fetched at PC in cycle N appears on the IF_ID_* outputs in cycle N+1.
- Branch penalty: when if_branch is high in cycle N, the fetch at branch_target happens in cycle N+1. The IF/ID content loaded at the edge ending cycle N is a bubble, because the hazard unit asserts IF_ID_Flush with the redirect.
- stall_cnt increments when PC_Keep && !if_branch && !Jump.
- flush_cnt increments when IF_ID_Flush.
- Both counters saturate at all-ones with no wrap.
- cnt_clr has priority over increment and clears to 0 at the next edge.
- No X propagation: every register has a defined reset value.

Test Plan:
- Reset release with no controls: imem_addr = 0x00400000, 0x00400004, 0x00400008 on successive cycles. IF_ID_PC4 lags by one cycle (0x00400004 first), and IF_ID_Valid rises one cycle after reset release.
- Load-use stall: PC_Keep = IF_ID_Hold = 1 for 1 cycle at PC = 0x00400008. PC stays 0x00400008 for 2 cycles, IF_ID fields are frozen for that cycle, and stall_cnt = 1.
- Jump at PC = 0x0040000C with jump_target = 0x00400100 and IF_ID_Flush = 1. Next imem_addr = 0x00400100, IF_ID_Valid = 0, IF_ID_Instruction = 0, and flush_cnt increments to 1.
- Simultaneous if_branch (target 0x00400200), Jump (target 0x00400300), PC_Keep, IF_ID_Hold and IF_ID_Flush. Next PC = 0x00400200, IF/ID is flushed (not held), and stall_cnt is unchanged.
- Wrap and alignment: branch_target = 0xFFFF_FFFE gives PC = 0xFFFF_FFFC, the next cycle gives 0x0000_0000, and IF_ID_PC4 = 0x0000_0000.
- Counter saturation and clear: with CNT_W = 4, hold PC_Keep for 20 cycles -> stall_cnt = 15. Then pulse cnt_clr while PC_Keep is still high -> stall_cnt = 0. Assert reset mid-stall -> all outputs return to their reset values immediately.
